// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: streams AES-128 round keys 10 down to 0 over valid/ready.
// Define AES_INV_KS_FWD_EN to accept the cipher key and forward-expand it first.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rkey_ready,
  output logic         rkey_valid,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_round,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EMIT, EXPAND} state_t;
  state_t state, state_d;
  logic [127:0] key_reg, inv_key;
  logic [3:0]   round;
  logic [31:0]  p3;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s, b;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = (x == 8'h00) ? 8'h00 : r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 10; k++)
      r = (4'(k) < i) ? xtime(r) : r;
    return {r, 24'h0};
  endfunction
  assign p3 = key_reg[31:0] ^ key_reg[63:32];
  assign inv_key = {key_reg[127:96] ^ sub_rot(p3) ^ rcon(round),
                    key_reg[127:96] ^ key_reg[95:64],
                    key_reg[95:64] ^ key_reg[63:32],
                    p3};
`ifdef AES_INV_KS_FWD_EN
  logic [127:0] fwd_key;
  logic [31:0]  n0, n1, n2;
  assign n0 = key_reg[127:96] ^ sub_rot(key_reg[31:0]) ^ rcon(round + 4'd1);
  assign n1 = n0 ^ key_reg[95:64];
  assign n2 = n1 ^ key_reg[63:32];
  assign fwd_key = {n0, n1, n2, n2 ^ key_reg[31:0]};
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
`ifdef AES_INV_KS_FWD_EN
      IDLE:    state_d = start ? EXPAND : IDLE;
      EXPAND:  state_d = (round == 4'd9) ? EMIT : EXPAND;
`else
      IDLE:    state_d = start ? EMIT : IDLE;
`endif
      EMIT:    state_d = (rkey_ready && round == 4'd0) ? IDLE : EMIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      key_reg <= '0;
      round   <= '0;
      done    <= 1'b0;
    end else begin
      done <= state == EMIT && rkey_ready && round == 4'd0;
      if (state == IDLE && start) begin
        key_reg <= key_in;
`ifdef AES_INV_KS_FWD_EN
        round   <= 4'd0;
      end else if (state == EXPAND) begin
        key_reg <= fwd_key;
        round   <= round + 4'd1;
`else
        round   <= 4'd10;
`endif
      end else if (state == EMIT && rkey_ready && round != 4'd0) begin
        key_reg <= inv_key;
        round   <= round - 4'd1;
      end
    end
  always_comb begin
    rkey_valid = state == EMIT;
    busy       = state != IDLE;
    rkey       = key_reg;
    rkey_round = round;
  end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed FIPS-197 round-key stream checks with backpressure and resets.
module tb_aes_inv_key_sched;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rkey_ready = 1'b0;
  logic [127:0] key_in = '0, rkey;
  logic         rkey_valid, busy, done;
  logic [3:0]   rkey_round;
  int n_tests = 0, n_fail = 0;
  logic [127:0] exp_key [0:10];
  aes_inv_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rkey_ready(rkey_ready),
    .rkey_valid(rkey_valid), .rkey(rkey), .rkey_round(rkey_round), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 128'(rkey_valid), 0);
    chk({tag, " rkey"}, rkey, 0);
    chk({tag, " round"}, 128'(rkey_round), 0);
    chk({tag, " busy"}, 128'(busy), 0);
    chk({tag, " done"}, 128'(done), 0);
  endtask
  task automatic begin_seq();
`ifdef AES_INV_KS_FWD_EN
    key_in = exp_key[0];
`else
    key_in = exp_key[10];
`endif
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef AES_INV_KS_FWD_EN
    for (int i = 0; i < 10; i++) begin
      chk("expand valid", 128'(rkey_valid), 0);
      chk("expand busy", 128'(busy), 1);
      step();
    end
`endif
    chk("first valid", 128'(rkey_valid), 1);
    chk("first round", 128'(rkey_round), 10);
    chk("first key", rkey, exp_key[10]);
  endtask
  // walks the stream; ready_mode 0 = always ready, 1 = random; optional start pulse at round 6
  task automatic run_stream(input bit rnd, input bit poke);
    int r = 10;
    int cyc = 0;
    while (r >= 0 && cyc < 400) begin
      chk("valid", 128'(rkey_valid), 1);
      chk("round", 128'(rkey_round), 128'(r));
      chk("key", rkey, exp_key[r]);
      rkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && r == 6;
      key_in = poke ? 128'h00112233445566778899aabbccddeeff : key_in;
      step();
      start = 1'b0;
      r = rkey_ready ? r - 1 : r;
      cyc++;
    end
    chk("stream finished", 128'(r), 128'(-1));
    chk("done pulse", 128'(done), 1);
    chk("busy low", 128'(busy), 0);
    chk("valid low", 128'(rkey_valid), 0);
    rkey_ready = 1'b0;
    step();
    chk("done one cycle", 128'(done), 0);
    chk("stays idle", 128'(busy), 0);
  endtask
  initial begin
    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    repeat (3) step();
    chk_idle("reset");
    key_in = exp_key[10];
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_idle("start in reset");
    rst_n = 1'b1;
    step();
    chk_idle("idle");
    begin_seq();
    run_stream(1'b0, 1'b0);
    begin_seq();
    run_stream(1'b1, 1'b0);
    begin_seq();
    run_stream(1'b0, 1'b1);
    begin_seq();
    rkey_ready = 1'b1;
    for (int i = 0; i < 40 && rkey_round != 4'd4; i++) step();
    chk("reached round 4", 128'(rkey_round), 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rkey_ready = 1'b0;
    chk_idle("mid reset");
    repeat (2) step();
    chk_idle("after mid reset");
    begin_seq();
    run_stream(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Streams AES-128 round keys from round 10 down to round 0. It is the reverse-direction counterpart of the forward key expansion and feeds the inverse-cipher datapath, which uses round keys in descending order. Each step undoes one forward expansion step and applies the round constant for the round being undone. Output uses a valid/ready handshake, so the decryption rounds can stall the schedule.

## Interface
- No parameters. Key width is fixed at 128 bits, with 10 rounds.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  load `key_in` and begin a key sequence. Sampled only in IDLE.
- key_in  in  128  round-10 key. Word w0 is in bits [127:96].
- rkey_ready  in  1  the consumer accepts `rkey` this cycle.
- rkey_valid  out  1  `rkey` and `rkey_round` are valid.
- rkey  out  128  current round key, same word order as `key_in`.
- rkey_round  out  4  round index of `rkey`, 10 down to 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the round-0 key is accepted.

## Operation
- States: IDLE, EMIT, plus EXPAND when the macro is defined.
- Inverse step, taking the round-i key (w0..w3) to the round-(i-1) key (p0..p3):
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i).
  - RotWord rotates left by one byte.
  - SubWord is four instances of the team S-box.
  - Rcon(i) for i=1..10 is 01,02,04,08,10,20,40,80,1b,36 in the top byte, with the low 24 bits zero.
- Rcon is indexed by the round being undone, i, never by i-1.
- IDLE:
  - start=1: key_reg <= key_in, round <= 10, go to EMIT.
  - start=0: hold.
- EMIT:
  - rkey_valid=1, rkey=key_reg, rkey_round=round.
  - On rkey_valid & rkey_ready with round>0: key_reg <= inv_step(key_reg, round), round <= round-1.
  - On rkey_valid & rkey_ready with round==0: go to IDLE, done <= 1 for one cycle.
  - Without rkey_ready: key_reg, round and rkey hold stable. `rkey` must not change while valid and not accepted.
- start is ignored while busy. A new sequence needs a return to IDLE; start in the same cycle as the final handshake is ignored.
- rst_n=0 at a clock edge, in any state including mid-sequence:
  - state goes to IDLE; key_reg, round, rkey_valid, busy and done clear.
  - no partial key is emitted afterwards.

## Timing
- Reset values: rkey_valid=0, rkey=0, rkey_round=0, busy=0, done=0.
- Outputs are registered or decoded from state only. No combinational path from rkey_ready to `rkey`.
- Start to first valid: the cycle after start is sampled, `rkey_valid`=1 with round 10.
- With rkey_ready held at 1:
  - one key per cycle, 11 keys in 11 consecutive cycles (rounds 10..0);
  - done pulses the cycle after round 0 is accepted;
  - busy falls in the same cycle done pulses.
- Throughput is one key per cycle, and the inverse step is single-cycle combinational.

## Configuration
- Macro `AES_INV_KS_FWD_EN`.
- Defined:
  - key_in is the cipher key (round 0).
  - On start, the block goes to EXPAND and runs 10 forward steps, one per cycle, using Rcon(r+1) for step r→r+1.
  - It then enters EMIT at round 10. First valid is 11 cycles after start.
  - busy is high during EXPAND, and rkey_valid is 0 during EXPAND.
- Not defined: EXPAND and the forward datapath are absent, and key_in is the round-10 key.

## Test plan
1. Reset check: hold rst_n=0 for 3 cycles → all outputs are 0. Apply start with rst_n=0 → no effect.
2. FIPS-197 stream, macro undefined, rkey_ready=1:
   - start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6;
   - round 10 = that key, round 9 = ac7766f319fadc2128d12941575c006e;
   - round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c;
   - done pulses exactly 11 cycles after the first valid.
3. Backpressure: toggle rkey_ready pseudo-randomly → same 11 keys in order. `rkey` and `rkey_round` stay stable whenever valid=1 and ready=0.
4. Start while busy: pulse start with a different key at round 6 → sequence continues unchanged, and the ignored key is never emitted.
5. Mid-sequence reset: assert rst_n=0 at round 4 → next cycle all outputs are 0. A new start then restarts cleanly at round 10.
6. With `AES_INV_KS_FWD_EN`: key_in=2b7e151628aed2a6abf7158809cf4f3c → first valid 11 cycles after start with rkey=d014f9a8…0ca6, then the same stream as test 2.
